// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector: valid/ready word load,
// one-deep holding register, one bit per clock on a. SER_PARITY_EN appends an even-parity bit.
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             a,
  output logic             a_valid,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef SER_PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt;
  logic             transfer;
  logic             shift_en;
`ifdef SER_PARITY_EN
  logic             par;
`endif

  assign shifted = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                             : {1'b0, shift_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A transfer moves the held word into the shifter; it only happens when
  // hold_full is set, so it never coincides with a load.
  always_comb begin
    next_state = state;
    transfer   = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          transfer   = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == LAST) begin
`ifdef SER_PARITY_EN
          next_state = PARITY;
`else
          if (hold_full) begin
            transfer   = 1'b1;
            next_state = SHIFT;
          end else begin
            next_state = IDLE;
          end
`endif
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        if (hold_full) begin
          transfer   = 1'b1;
          next_state = SHIFT;
        end else begin
          next_state = IDLE;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_data <= '0;
      hold_full <= 1'b0;
      shift_reg <= '0;
      cnt       <= '0;
`ifdef SER_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      if (transfer) begin
        shift_reg <= hold_data;
        hold_full <= 1'b0;
        cnt       <= '0;
`ifdef SER_PARITY_EN
        par       <= ^hold_data;
`endif
      end else begin
        if (shift_en) begin
          shift_reg <= shifted;
          cnt       <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
        if (load_valid && !hold_full) begin
          hold_data <= data_in;
          hold_full <= 1'b1;
        end
      end
    end
  end

  // Outputs decode registers only; nothing combinational from the inputs.
  always_comb begin
    a       = IDLE_LEVEL;
    a_valid = 1'b0;
    case (state)
      SHIFT: begin
        a       = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
        a_valid = 1'b1;
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        a       = par;
        a_valid = 1'b1;
      end
`endif
      default: begin
        a       = IDLE_LEVEL;
        a_valid = 1'b0;
      end
    endcase
  end

  assign load_ready = !hold_full;
  assign busy       = (state != IDLE) || hold_full;

endmodule
